// File: rtl/mmr_intr_pkg.sv
// Shared types and default widths for the MMR interrupt controller.
package mmr_intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } intr_fsm_e;

  localparam int unsigned DEF_N     = 32;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_TMR_W = 16;

endpackage

// File: rtl/mmr_intr_coalescer.sv
// Interrupt coalescing FSM: event-count threshold, timeout and post-IRQ holdoff.
module mmr_intr_coalescer
  import mmr_intr_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TMR_W = DEF_TMR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pending,
  input  logic             uev,
  input  logic [CNT_W-1:0] coal_cnt,
  input  logic [TMR_W-1:0] coal_tmo,
  input  logic [TMR_W-1:0] holdoff,
  output logic             irq,
  output intr_fsm_e        state,
  output logic [CNT_W-1:0] ev_cnt
);

  logic [TMR_W-1:0] timer;
  logic             tmo_hit;
  logic             hold_done;

  assign tmo_hit   = (coal_tmo != '0) && (timer >= coal_tmo);
  // Widened compare handles a live holdoff of 0 without underflowing holdoff-1.
  assign hold_done = ({1'b0, timer} + (TMR_W+1)'(1)) >= {1'b0, holdoff};

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ev_cnt <= '0;
      timer  <= '0;
      irq    <= 1'b0;
    end else begin
      if (uev && (state != ASSERT) && (ev_cnt != '1))
        ev_cnt <= ev_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (pending) begin
            if (coal_cnt <= CNT_W'(1)) begin
              state  <= ASSERT;
              irq    <= 1'b1;
              ev_cnt <= '0;
            end else begin
              state <= COUNT;
              timer <= '0;
            end
          end
        end
        COUNT: begin
          if (timer != '1)
            timer <= timer + TMR_W'(1);
          if (!pending) begin
            state  <= IDLE;
            ev_cnt <= '0;
          end else if ((ev_cnt >= coal_cnt) || tmo_hit) begin
            state  <= ASSERT;
            irq    <= 1'b1;
            ev_cnt <= '0;
          end
        end
        ASSERT: begin
          if (!pending) begin
            irq <= 1'b0;
            if (holdoff == '0) begin
              state <= IDLE;
            end else begin
              state <= HOLDOFF;
              timer <= '0;
            end
          end
        end
        HOLDOFF: begin
          if (timer != '1)
            timer <= timer + TMR_W'(1);
          if (hold_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mmr_intr_controller.sv
// ISR/IMR register bank feeding the coalescer that drives the CPU IRQ line.
module mmr_intr_controller
  import mmr_intr_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TMR_W = DEF_TMR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     isr_pulses,
  input  logic             imr_wr,
  input  logic [N-1:0]     imr_wdata,
  input  logic             isr_clr,
  input  logic [N-1:0]     isr_clr_mask,
  input  logic [CNT_W-1:0] coal_cnt,
  input  logic [TMR_W-1:0] coal_tmo,
  input  logic [TMR_W-1:0] holdoff,
  output logic [N-1:0]     imr,
  output logic [N-1:0]     isr,
  output logic             irq,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] ev_cnt
);

  logic [N-1:0] clr_eff;
  logic         pending;
  logic         uev;
  intr_fsm_e    coal_state;

  assign clr_eff = isr_clr ? isr_clr_mask : '0;
  assign pending = |(isr & imr);
  assign uev     = |(isr_pulses & imr);

  // New pulses are OR'd in after the clear so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      isr <= '0;
      imr <= '0;
    end else begin
      isr <= (isr & ~clr_eff) | isr_pulses;
      if (imr_wr)
        imr <= imr_wdata;
    end
  end

  mmr_intr_coalescer #(
    .CNT_W(CNT_W),
    .TMR_W(TMR_W)
  ) u_coalescer (
    .clock    (clock),
    .reset    (reset),
    .pending  (pending),
    .uev      (uev),
    .coal_cnt (coal_cnt),
    .coal_tmo (coal_tmo),
    .holdoff  (holdoff),
    .irq      (irq),
    .state    (coal_state),
    .ev_cnt   (ev_cnt)
  );

  assign fsm_state = coal_state;

endmodule
